// File: rtl/hpc3_rnd_pkg.sv
// Shared constants, FSM state type and the LFSR advance function for the
// HPC3 fresh-randomness source.
package hpc3_rnd_pkg;

  localparam int LFSR_W     = 128;
  localparam int TAP_A      = 127;
  localparam int TAP_B      = 125;
  localparam int TAP_C      = 100;
  localparam int TAP_D      = 98;
  localparam int SEED_W     = 32;
  localparam int SEED_BEATS = 4;

  typedef enum logic [1:0] {
    UNSEEDED,
    LOAD,
    WARMUP,
    RUN
  } rnd_state_e;

  typedef struct packed {
    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] bits;
  } lfsr_adv_t;

  // Runs nbits LFSR steps; bits[i] is the feedback bit of step i.
  function automatic lfsr_adv_t lfsr_advance(input logic [LFSR_W-1:0] s, input int nbits);
    lfsr_adv_t r;
    logic      fb;
    r.state = s;
    r.bits  = '0;
    for (int i = 0; i < LFSR_W; i++) begin
      if (i < nbits) begin
        fb        = r.state[TAP_A] ^ r.state[TAP_B] ^ r.state[TAP_C] ^ r.state[TAP_D];
        r.bits[i] = fb;
        r.state   = {r.state[LFSR_W-2:0], fb};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hpc3_rnd_source_lfsr_step.sv
// Combinational multi-step LFSR advance, shared by the warm-up and run paths.
module hpc3_lfsr_step
  import hpc3_rnd_pkg::*;
#(
  parameter int NBITS = 2
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [NBITS-1:0]  bits_o
);

  lfsr_adv_t         adv;
  logic [LFSR_W-1:0] unusedBits;

  always_comb begin
    adv        = lfsr_advance(state_i, NBITS);
    state_o    = adv.state;
    bits_o     = adv.bits[NBITS-1:0];
    unusedBits = adv.bits;
  end

endmodule

// File: rtl/hpc3_rnd_source.sv
// Seeded LFSR randomness producer feeding the r inputs of the HPC3 gadgets.
// Each delivered word is handed out exactly once via valid/ready.
module hpc3_rnd_source
  import hpc3_rnd_pkg::*;
#(
  parameter int SECURITY_ORDER  = 1,
  parameter int RND_BITS        = SECURITY_ORDER * (SECURITY_ORDER + 1),
  parameter int WARMUP_CYCLES   = 128,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEED_W-1:0]   seed_data_i,
  input  logic                seed_valid_i,
  output logic                seed_ready_o,
  output logic [RND_BITS-1:0] rnd_o,
  output logic                rnd_valid_o,
  input  logic                rnd_ready_i,
  output logic                reseed_req_o
);

  localparam int WARM_CW   = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int RESEED_CW = $clog2(RESEED_INTERVAL + 1);
  localparam logic [WARM_CW-1:0]   WARM_LAST  = WARM_CW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [RESEED_CW-1:0] RESEED_MAX = RESEED_CW'(RESEED_INTERVAL);
  localparam logic [1:0]           LAST_BEAT  = 2'(SEED_BEATS - 1);

  rnd_state_e           state_q;
  logic [LFSR_W-1:0]    lfsr_q;
  logic [RND_BITS-1:0]  rndWord_q;
  logic                 rndValid_q;
  logic                 seedReady_q;
  logic [1:0]           beatCnt_q;
  logic [WARM_CW-1:0]   warmCnt_q;
  logic [RESEED_CW-1:0] reseedCnt_q;

  logic                 seedBeat;
  logic                 rndTake;
  logic [LFSR_W-1:0]    lfsrSeed_d;
  logic [LFSR_W-1:0]    lfsrSeedFix_d;
  logic [LFSR_W-1:0]    stepState;
  logic [RND_BITS-1:0]  stepBits;

  assign seedBeat      = seed_valid_i & seedReady_q;
  assign rndTake       = rndValid_q & rnd_ready_i;
  assign lfsrSeed_d    = {lfsr_q[LFSR_W-SEED_W-1:0], seed_data_i};
  // An all-zero seed would lock the LFSR, so it is nudged to state 1.
  assign lfsrSeedFix_d = (lfsrSeed_d == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : lfsrSeed_d;

  hpc3_lfsr_step #(
    .NBITS(RND_BITS)
  ) u_step (
    .state_i(lfsr_q),
    .state_o(stepState),
    .bits_o (stepBits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNSEEDED;
      lfsr_q      <= '0;
      rndWord_q   <= '0;
      rndValid_q  <= 1'b0;
      seedReady_q <= 1'b0;
      beatCnt_q   <= '0;
      warmCnt_q   <= '0;
      reseedCnt_q <= '0;
    end else begin
      if (rndTake && (reseedCnt_q != RESEED_MAX)) begin
        reseedCnt_q <= reseedCnt_q + RESEED_CW'(1);
      end
      unique case (state_q)
        UNSEEDED: begin
          seedReady_q <= 1'b1;
          if (seedBeat) begin
            lfsr_q    <= lfsrSeed_d;
            beatCnt_q <= 2'd1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (seedBeat) begin
            if (beatCnt_q == LAST_BEAT) begin
              lfsr_q      <= lfsrSeedFix_d;
              beatCnt_q   <= '0;
              warmCnt_q   <= '0;
              reseedCnt_q <= '0;
              if (WARMUP_CYCLES == 0) begin
                state_q <= RUN;
              end else begin
                state_q     <= WARMUP;
                seedReady_q <= 1'b0;
              end
            end else begin
              lfsr_q    <= lfsrSeed_d;
              beatCnt_q <= beatCnt_q + 2'd1;
            end
          end
        end
        WARMUP: begin
          lfsr_q    <= stepState;
          warmCnt_q <= warmCnt_q + WARM_CW'(1);
          if (warmCnt_q == WARM_LAST) begin
            state_q     <= RUN;
            seedReady_q <= 1'b1;
          end
        end
        RUN: begin
          // A seed beat abandons the pending word; a handshake in the same
          // cycle has already been counted above.
          if (seedBeat) begin
            lfsr_q     <= lfsrSeed_d;
            beatCnt_q  <= 2'd1;
            rndValid_q <= 1'b0;
            state_q    <= LOAD;
          end else if (!rndValid_q || rnd_ready_i) begin
            lfsr_q     <= stepState;
            rndWord_q  <= stepBits;
            rndValid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign seed_ready_o = seedReady_q;
  assign rnd_o        = rndWord_q;
  assign rnd_valid_o  = rndValid_q;
  assign reseed_req_o = (reseedCnt_q >= RESEED_MAX);

endmodule

// File: tb/tb_hpc3_rnd_source.sv
// Directed bench for hpc3_rnd_source: an independent LFSR model fills a
// scoreboard queue at each seed and every delivered word is popped against it.
module tb_hpc3_rnd_source;

  localparam int RB = 2;
  localparam int WU = 3;
  localparam int RI = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   seedData;
  logic          seedValid;
  logic          seedReady;
  logic [RB-1:0] rnd;
  logic          rndValid;
  logic          rndReady;
  logic          reseedReq;

  int            checks = 0;
  int            errors = 0;
  int            sinceSeed = 0;
  logic [127:0]  modelS;
  logic [RB-1:0] expQ[$];

  hpc3_rnd_source #(
    .SECURITY_ORDER (1),
    .RND_BITS       (RB),
    .WARMUP_CYCLES  (WU),
    .RESEED_INTERVAL(RI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_data_i (seedData),
    .seed_valid_i(seedValid),
    .seed_ready_o(seedReady),
    .rnd_o       (rnd),
    .rnd_valid_o (rndValid),
    .rnd_ready_i (rndReady),
    .reseed_req_o(reseedReq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference LFSR: one advance of RB single steps, first feedback bit in bit 0.
  task automatic modelAdvance(output logic [RB-1:0] w);
    logic fb;
    w = '0;
    for (int i = 0; i < RB; i++) begin
      fb     = modelS[127] ^ modelS[125] ^ modelS[100] ^ modelS[98];
      w[i]   = fb;
      modelS = {modelS[126:0], fb};
    end
  endtask

  // Drives four seed beats, then refills the scoreboard from the model.
  // Returns on the negedge after the last beat, with seed_valid dropped.
  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0]   beats[4];
    logic [RB-1:0] word;
    beats = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("seed_ready_beat", seedReady, 1'b1);
      if (i > 0) checkOutput("valid_in_load", rndValid, 1'b0);
      seedValid = 1'b1;
      seedData  = beats[i];
    end
    @(negedge clk);
    seedValid = 1'b0;
    seedData  = '0;
    modelS = {w0, w1, w2, w3};
    if (modelS == '0) modelS = 128'd1;
    for (int i = 0; i < WU; i++) modelAdvance(word);
    expQ.delete();
    for (int i = 0; i < 200; i++) begin
      modelAdvance(word);
      expQ.push_back(word);
    end
    sinceSeed = 0;
  endtask

  task automatic waitValid();
    int k = 1;
    while (rndValid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("first_valid_latency", k, WU + 2);
  endtask

  task automatic consumeWords(input int n);
    int            taken = 0;
    int            cycles = 0;
    logic [RB-1:0] expWord;
    while (taken < n && cycles < 200) begin
      @(negedge clk);
      cycles++;
      checkOutput("reseed_req", reseedReq, (sinceSeed >= RI));
      if (rndValid === 1'b1) begin
        expWord = expQ.pop_front();
        checkOutput("rnd_word", rnd, expWord);
        rndReady = 1'b1;
        taken++;
        sinceSeed++;
      end else begin
        rndReady = 1'b0;
      end
    end
    checkOutput("consume_count", taken, n);
    @(negedge clk);
    rndReady = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    seedData  = '0;
    seedValid = 1'b0;
    rndReady  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_valid", rndValid, 1'b0);
    checkOutput("reset_seed_ready", seedReady, 1'b0);
    checkOutput("reset_rnd", rnd, '0);
    checkOutput("reset_reseed", reseedReq, 1'b0);
    rst_n = 1'b1;

    $display("[TB] idle unseeded");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("idle_valid", rndValid, 1'b0);
      checkOutput("idle_seed_ready", seedReady, 1'b1);
      checkOutput("idle_reseed", reseedReq, 1'b0);
    end

    $display("[TB] seed 0,0,0,1");
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h1);
    waitValid();
    consumeWords(49);

    $display("[TB] all-zero seed during RUN");
    checkOutput("run_valid_before_abort", rndValid, 1'b1);
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
    waitValid();
    consumeWords(49);

    $display("[TB] backpressure");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", rndValid, 1'b1);
      checkOutput("stall_rnd", rnd, expQ[0]);
    end
    consumeWords(20);

    $display("[TB] abort pending word");
    checkOutput("pending_valid", rndValid, 1'b1);
    applyStimulus(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C);
    waitValid();
    consumeWords(6);

    $display("[TB] reset during warm-up");
    applyStimulus(32'h13579BDF, 32'h2468ACE0, 32'hCAFEF00D, 32'h55AA33CC);
    checkOutput("warmup_seed_ready", seedReady, 1'b0);
    checkOutput("warmup_valid", rndValid, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", rndValid, 1'b0);
    checkOutput("async_rst_seed_ready", seedReady, 1'b0);
    checkOutput("async_rst_rnd", rnd, '0);
    checkOutput("async_rst_reseed", reseedReq, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00FF00FF, 32'hFF00FF00);
    waitValid();
    consumeWords(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
